// File: rtl/qspi_flash_responder_if.sv
// Bus bundle between a QSPI flash responder and its controller/backing store.
// The slave modport is the responder's view; master is the driving side.
interface qspi_flash_responder_if #(
   parameter int ADDR_BITS = 24
);
   logic                 spi_clk;
   logic                 spi_select;
   logic [3:0]           spi_data_in;
   logic [3:0]           spi_data_out;
   logic [3:0]           spi_data_oe;
   logic [ADDR_BITS-1:0] mem_addr;
   logic                 mem_rd;
   logic [7:0]           mem_rdata;
   logic                 cont_mode;

   modport slave (
      input  spi_clk, spi_select, spi_data_in, mem_rdata,
      output spi_data_out, spi_data_oe, mem_addr, mem_rd, cont_mode
   );

   modport master (
      output spi_clk, spi_select, spi_data_in, mem_rdata,
      input  spi_data_out, spi_data_oe, mem_addr, mem_rd, cont_mode
   );
endinterface

// File: rtl/qspi_flash_responder.sv
// Flash-side responder for Fast Read Quad I/O (0xEB) with continuous-read mode.
// spi_clk is oversampled by clk; inputs taken on SPI rise, outputs driven on SPI fall.
module qspi_flash_responder #(
   parameter int ADDR_BITS    = 24,
   parameter int DUMMY_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rstn,
   qspi_flash_responder_if.slave bus
);

   localparam int CNT_W = (DUMMY_CYCLES > 7) ? $clog2(DUMMY_CYCLES + 1) : 3;
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(5);
   localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      MODE,
      DUMMY,
      DATA,
      IGNORE
   } state_t;

   state_t               state_q, state_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic                 cont_q, cont_n;
   logic [3:0]           out_q, out_n;
   logic [3:0]           oe_q, oe_n;
   logic [ADDR_BITS-1:0] addr_q, addr_n;
   logic                 rd_q, rd_n;
   logic                 half_q, half_n;
   logic                 rd_vld_p1;
   logic                 spi_clk_q;
   logic [19:0]          sh_q, sh_n;
   logic [7:0]           byte_q;
   logic [7:0]           cur_byte;
   logic [23:0]          addr_full;
   logic                 rise, fall;

   assign rise = bus.spi_clk & ~spi_clk_q;
   assign fall = ~bus.spi_clk & spi_clk_q;

   // Fetched byte may arrive in the same clk as the fall that needs it.
   assign cur_byte  = rd_vld_p1 ? bus.mem_rdata : byte_q;
   assign addr_full = {sh_q, bus.spi_data_in};

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      sh_n    = sh_q;
      cont_n  = cont_q;
      out_n   = out_q;
      oe_n    = oe_q;
      addr_n  = addr_q;
      rd_n    = 1'b0;
      half_n  = half_q;

      if (bus.spi_select) begin
         state_n = IDLE;
         oe_n    = 4'h0;
         cnt_n   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_n   = '0;
               sh_n    = '0;
               state_n = cont_q ? ADDR : CMD;
            end
            CMD: if (rise) begin
               sh_n  = {sh_q[18:0], bus.spi_data_in[0]};
               cnt_n = cnt_q + 1'b1;
               if (cnt_q == CMD_LAST) begin
                  cnt_n = '0;
                  if ({sh_q[6:0], bus.spi_data_in[0]} == 8'hEB) begin
                     state_n = ADDR;
                  end else begin
                     state_n = IGNORE;
                     cont_n  = 1'b0;
                  end
               end
            end
            ADDR: if (rise) begin
               sh_n  = {sh_q[15:0], bus.spi_data_in};
               cnt_n = cnt_q + 1'b1;
               if (cnt_q == ADDR_LAST) begin
                  addr_n  = ADDR_BITS'(addr_full);
                  rd_n    = 1'b1;
                  cnt_n   = '0;
                  state_n = MODE;
               end
            end
            MODE: if (rise) begin
               if (cnt_q == '0) begin
                  sh_n  = {sh_q[15:0], bus.spi_data_in};
                  cnt_n = CNT_W'(1);
               end else begin
                  // sh_q[1:0] holds mode bits [5:4] from the high nibble.
                  cont_n  = (sh_q[1:0] == 2'b10);
                  cnt_n   = '0;
                  state_n = DUMMY;
               end
            end
            DUMMY: begin
               if (rise && cnt_q != DUMMY_LAST) begin
                  cnt_n = cnt_q + 1'b1;
               end
               if (fall && cnt_q == DUMMY_LAST) begin
                  out_n   = cur_byte[7:4];
                  oe_n    = 4'hF;
                  half_n  = 1'b1;
                  state_n = DATA;
               end
            end
            DATA: begin
               if (fall) begin
                  out_n  = half_q ? cur_byte[3:0] : cur_byte[7:4];
                  half_n = ~half_q;
               end
               // Low nibble consumed: prefetch the next byte before the next fall.
               if (rise && !half_q) begin
                  addr_n = addr_q + 1'b1;
                  rd_n   = 1'b1;
               end
            end
            IGNORE: oe_n = 4'h0;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cont_q    <= 1'b0;
         out_q     <= 4'h0;
         oe_q      <= 4'h0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         half_q    <= 1'b0;
         rd_vld_p1 <= 1'b0;
         spi_clk_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         cont_q    <= cont_n;
         out_q     <= out_n;
         oe_q      <= oe_n;
         addr_q    <= addr_n;
         rd_q      <= rd_n;
         half_q    <= half_n;
         rd_vld_p1 <= rd_q;
         spi_clk_q <= bus.spi_clk;
      end
   end

   // p1: read data returns one clk after the strobe
   always_ff @(posedge clk) begin
      sh_q <= sh_n;
      if (rd_vld_p1) begin
         byte_q <= bus.mem_rdata;
      end
   end

   assign bus.spi_data_out = out_q;
   assign bus.spi_data_oe  = oe_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_rd       = rd_q;
   assign bus.cont_mode    = cont_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: a 24-bit and an 8-bit address instance driven
// in lockstep, checked against a byte-stream model of the flash read protocol.
module tb_qspi_flash_responder;

   localparam int HALF  = 3;
   localparam int DUMMY = 4;

   logic clk = 1'b0;
   logic rstn;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   qspi_flash_responder_if #(.ADDR_BITS(24)) b24 ();
   qspi_flash_responder_if #(.ADDR_BITS(8))  b8 ();

   qspi_flash_responder #(.ADDR_BITS(24), .DUMMY_CYCLES(DUMMY)) dut24 (
      .clk(clk), .rstn(rstn), .bus(b24));
   qspi_flash_responder #(.ADDR_BITS(8), .DUMMY_CYCLES(DUMMY)) dut8 (
      .clk(clk), .rstn(rstn), .bus(b8));

   logic [7:0]  mem [int unsigned];
   int unsigned q24 [$];
   int unsigned q8  [$];
   logic [3:0]  o24, e24, o8, e8;
   bit          cont_m;

   function automatic logic [7:0] mem_lookup(input int unsigned a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ 8'hC3;
   endfunction

   // Backing store: synchronous read, data one clk after the strobe.
   always @(posedge clk) begin
      if (!rstn) begin
         b24.mem_rdata <= 8'h00;
         b8.mem_rdata  <= 8'h00;
      end else begin
         if (b24.mem_rd) begin
            b24.mem_rdata <= mem_lookup(32'(b24.mem_addr));
            q24.push_back(32'(b24.mem_addr));
         end
         if (b8.mem_rd) begin
            b8.mem_rdata <= mem_lookup(32'(b8.mem_addr));
            q8.push_back(32'(b8.mem_addr));
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input logic v);
      b24.spi_select = v;
      b8.spi_select  = v;
   endtask

   task automatic set_sclk(input logic v);
      b24.spi_clk = v;
      b8.spi_clk  = v;
   endtask

   // One SPI clock: data presented in the low phase, responder output sampled just before the rise.
   task automatic spi_cycle(input logic [3:0] din);
      b24.spi_data_in = din;
      b8.spi_data_in  = din;
      tick(HALF);
      o24 = b24.spi_data_out; e24 = b24.spi_data_oe;
      o8  = b8.spi_data_out;  e8  = b8.spi_data_oe;
      set_sclk(1'b1);
      tick(HALF);
      set_sclk(1'b0);
   endtask

   function automatic logic [3:0] nib(input logic [7:0] b, input int k);
      return (k % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   task automatic deselect();
      set_sclk(1'b0);
      set_sel(1'b1);
      tick(3);
      chk("oe_deselect24", 32'(b24.spi_data_oe), 32'h0);
      chk("oe_deselect8",  32'(b8.spi_data_oe),  32'h0);
      chk("cont_held24",   32'(b24.cont_mode),   32'(cont_m));
   endtask

   task automatic txn_body(input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [7:0] mode, input int nbytes);
      bit          send_cmd;
      bit          ok;
      logic [3:0]  pre24, pre8;
      int unsigned a;
      send_cmd = !cont_m;
      ok       = !send_cmd || (cmd == 8'hEB);
      pre24    = 4'h0;
      pre8     = 4'h0;
      q24.delete();
      q8.delete();
      set_sel(1'b0);
      tick(2);
      if (send_cmd)
         for (int i = 7; i >= 0; i--) begin
            spi_cycle({3'($urandom), cmd[i]});
            pre24 |= e24; pre8 |= e8;
         end
      for (int i = 5; i >= 0; i--) begin
         spi_cycle(addr[4*i +: 4]);
         pre24 |= e24; pre8 |= e8;
      end
      spi_cycle(mode[7:4]); pre24 |= e24; pre8 |= e8;
      spi_cycle(mode[3:0]); pre24 |= e24; pre8 |= e8;
      for (int i = 0; i < DUMMY; i++) begin
         spi_cycle(4'($urandom));
         pre24 |= e24; pre8 |= e8;
      end
      cont_m = ok && (mode[5:4] == 2'b10);
      chk("oe_before_data24", 32'(pre24), 32'h0);
      chk("oe_before_data8",  32'(pre8),  32'h0);
      for (int k = 0; k < 2 * nbytes; k++) begin
         spi_cycle(4'($urandom));
         if (ok) begin
            a = 32'(addr) + 32'(k / 2);
            chk("nibble24", 32'(o24), 32'(nib(mem_lookup(a & 32'hFF_FFFF), k)));
            chk("oe_data24", 32'(e24), 32'hF);
            chk("nibble8",  32'(o8),  32'(nib(mem_lookup(a & 32'hFF), k)));
            chk("oe_data8",  32'(e8),  32'hF);
         end else begin
            pre24 |= e24; pre8 |= e8;
         end
      end
      if (!ok) begin
         chk("oe_ignore24", 32'(pre24), 32'h0);
         chk("oe_ignore8",  32'(pre8),  32'h0);
      end
      chk("cont24", 32'(b24.cont_mode), 32'(cont_m));
      chk("cont8",  32'(b8.cont_mode),  32'(cont_m));
      chk("rd_count24", q24.size(), ok ? nbytes + 1 : 0);
      chk("rd_count8",  q8.size(),  ok ? nbytes + 1 : 0);
      if (ok)
         for (int i = 0; i <= nbytes && i < q24.size() && i < q8.size(); i++) begin
            a = 32'(addr) + 32'(i);
            chk("rd_addr24", q24[i], a & 32'hFF_FFFF);
            chk("rd_addr8",  q8[i],  a & 32'hFF);
         end
   endtask

   task automatic txn(input logic [7:0] cmd, input logic [23:0] addr,
                      input logic [7:0] mode, input int nbytes);
      txn_body(cmd, addr, mode, nbytes);
      deselect();
   endtask

   initial begin
      logic [23:0] ra;
      logic [7:0]  rm, rc;
      int          rn;
      rstn = 1'b0;
      set_sel(1'b1);
      set_sclk(1'b0);
      b24.spi_data_in = 4'h0;
      b8.spi_data_in  = 4'h0;
      cont_m = 1'b0;
      tick(3);
      chk("rst_oe",    32'(b24.spi_data_oe),  32'h0);
      chk("rst_out",   32'(b24.spi_data_out), 32'h0);
      chk("rst_rd",    32'(b24.mem_rd),       32'h0);
      chk("rst_addr",  32'(b24.mem_addr),     32'h0);
      chk("rst_cont",  32'(b24.cont_mode),    32'h0);
      rstn = 1'b1;
      tick(2);

      // Plain quad read
      mem[32'h10] = 8'h11; mem[32'h11] = 8'h22; mem[32'h12] = 8'h33; mem[32'h13] = 8'h44;
      txn(8'hEB, 24'h000010, 8'h00, 4);

      // Continuous-read entry, command-less access, exit with mode FF
      mem[32'h100] = 8'h5A;
      txn(8'hEB, 24'h000010, 8'hA0, 1);
      txn(8'h00, 24'h000100, 8'hA0, 1);
      txn(8'h00, 24'h000100, 8'hFF, 1);

      // Unsupported command
      txn(8'h03, 24'h000010, 8'h00, 2);

      // 8-bit instance wraps FF -> 00
      mem[32'hFF] = 8'h3C;
      txn(8'hEB, 24'h0000FF, 8'h00, 2);

      // Deselect part-way through the address
      q24.delete();
      set_sel(1'b0);
      tick(2);
      for (int i = 7; i >= 0; i--) spi_cycle({3'b000, 8'hEB >> i} & 4'h1);
      for (int i = 0; i < 3; i++) spi_cycle(4'hA + 4'(i));
      deselect();
      chk("rd_abort24", q24.size(), 0);
      mem[32'h20] = 8'($urandom);
      txn(8'hEB, 24'h000020, 8'h00, 1);

      // Randomized transactions
      for (int r = 0; r < 8; r++) begin
         rc = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hEB;
         ra = (r % 3 == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 2)) : 24'($urandom);
         rm = 8'($urandom);
         if ($urandom_range(0, 1) == 1) rm[5:4] = 2'b10;
         rn = $urandom_range(1, 4);
         for (int i = 0; i <= rn; i++) mem[(32'(ra) + 32'(i)) & 32'hFF_FFFF] = 8'($urandom);
         txn(rc, ra, rm, rn);
      end

      // Reset during DATA while in continuous mode
      if (!cont_m) txn(8'hEB, 24'h000040, 8'hA0, 1);
      txn_body(8'h00, 24'h000050, 8'hA0, 1);
      rstn = 1'b0;
      #1;
      chk("rst_mid_oe24",   32'(b24.spi_data_oe), 32'h0);
      chk("rst_mid_cont24", 32'(b24.cont_mode),   32'h0);
      chk("rst_mid_oe8",    32'(b8.spi_data_oe),  32'h0);
      chk("rst_mid_cont8",  32'(b8.cont_mode),    32'h0);
      cont_m = 1'b0;
      set_sel(1'b1);
      tick(2);
      rstn = 1'b1;
      tick(2);
      txn(8'hEB, 24'h000013, 8'h00, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
